// File: rtl/dsp_dot_ctrl.sv
// Dot-product sequencer for a fully pipelined DSP slice used as a MAC engine.
// Issues operand pairs with per-element opmodes and captures PCOUT when the last product lands.
module dsp_dot_ctrl #(
  parameter int N       = 18,
  parameter int PW      = 48,
  parameter int LEN_W   = 8,
  parameter int OPM_DLY = 3,
  parameter int P_DLY   = 5
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PW-1:0]    res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [N-1:0]     dsp_a,
  output logic [N-1:0]     dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_carryin,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [PW-1:0]    dsp_p
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;
  localparam logic [7:0] OPM_HOLD = 8'h08;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             first;
  logic             accept;
  logic             last_in;
  logic             cap;

  // Stage s holds the tag of the pair accepted s cycles earlier; the first flag
  // is only consumed at the opmode stage, so its pipeline stops there.
  logic [P_DLY:1]     tag_v;
  logic [P_DLY:1]     tag_l;
  logic [OPM_DLY-1:1] tag_f;

  assign accept      = in_valid & in_ready;
  assign last_in     = (remaining == LEN_W'(1));
  assign cap         = tag_v[P_DLY] & tag_l[P_DLY];
  assign dsp_ce      = 1'b1;
  assign dsp_carryin = 1'b0;

  always_ff @(posedge CLK) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (accept && last_in) state_nxt = DRAIN;
      DRAIN:   if (cap) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == RUN);
    res_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      remaining  <= '0;
      first      <= 1'b0;
      tag_v      <= '0;
      tag_l      <= '0;
      tag_f      <= '0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_opmode <= 8'h00;
      res_data   <= '0;
      dsp_rst    <= 1'b1;
    end else begin
      dsp_rst <= 1'b0;

      for (int unsigned s = P_DLY; s > 1; s--) begin
        tag_v[s] <= tag_v[s-1];
        tag_l[s] <= tag_l[s-1];
      end
      for (int unsigned s = OPM_DLY - 1; s > 1; s--) tag_f[s] <= tag_f[s-1];
      tag_v[1] <= accept;
      tag_l[1] <= accept & last_in;
      tag_f[1] <= accept & first;

      if (state == IDLE && start) begin
        remaining <= len;
        first     <= 1'b1;
        if (len == '0) res_data <= '0;
      end

      if (accept) begin
        dsp_a     <= in_a;
        dsp_b     <= in_b;
        remaining <= remaining - LEN_W'(1);
        first     <= 1'b0;
      end

      if (state == DRAIN && cap) res_data <= dsp_p;

      // Bubbles and idle states issue Z=P, X=0 so the slice P register holds.
      if (state == RUN || state == DRAIN) begin
        if (tag_v[OPM_DLY-1]) dsp_opmode <= tag_f[OPM_DLY-1] ? OPM_LOAD : OPM_ACC;
        else                  dsp_opmode <= OPM_HOLD;
      end else begin
        dsp_opmode <= OPM_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_dsp_dot_ctrl.sv
// Bench for dsp_dot_ctrl: behavioural DSP slice model plus a result scoreboard.
module tb_dsp_dot_ctrl;
  localparam int N       = 18;
  localparam int PW      = 48;
  localparam int LEN_W   = 8;
  localparam int OPM_DLY = 3;
  localparam int P_DLY   = 5;

  logic             CLK;
  logic             RSTN;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [N-1:0]     in_a, in_b;
  logic             in_valid, in_ready;
  logic [PW-1:0]    res_data;
  logic             res_valid, res_ready;
  logic             busy;
  logic [N-1:0]     dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_carryin, dsp_ce, dsp_rst;
  logic [PW-1:0]    dsp_p;

  dsp_dot_ctrl #(.N(N), .PW(PW), .LEN_W(LEN_W), .OPM_DLY(OPM_DLY), .P_DLY(P_DLY)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .len(len),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_carryin(dsp_carryin), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  logic [7:0]    opm_hist [0:4095];
  logic [PW-1:0] sb [$];
  logic [N-1:0]  job_a [0:15];
  logic [N-1:0]  job_b [0:15];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] prod_ext(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] pr;
    pr = $signed(a) * $signed(b);
    return {{(PW-2*N){pr[2*N-1]}}, pr};
  endfunction

  // Slice model: A0/A1, B0/B1, M, OPMODE and P registers, all clock-enabled by CE.
  logic [N-1:0]    s_a0, s_a1, s_b0, s_b1;
  logic [PW-1:0]   s_m, s_p;
  logic [7:0]      s_opm;
  always @(posedge CLK) begin
    if (dsp_rst) begin
      s_a0 <= '0; s_a1 <= '0; s_b0 <= '0; s_b1 <= '0;
      s_m <= '0; s_opm <= '0; s_p <= '0;
    end else if (dsp_ce) begin
      s_a0  <= dsp_a;
      s_a1  <= s_a0;
      s_b0  <= dsp_b;
      s_b1  <= s_b0;
      s_m   <= prod_ext(s_a1, s_b1);
      s_opm <= dsp_opmode;
      s_p   <= (s_opm[3] ? s_p : '0) + ((s_opm[1:0] == 2'b01) ? s_m : '0);
    end
  end
  assign dsp_p = s_p;

  always @(posedge CLK) ncyc <= ncyc + 1;
  always @(negedge CLK) opm_hist[ncyc % 4096] <= dsp_opmode;

  // Result monitor: every handshake pops and compares one expected result.
  always @(negedge CLK) begin
    if (RSTN && res_valid && res_ready) begin
      check_val("sb_has_exp", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) check_val("res_data", 64'(res_data), 64'(sb.pop_front()));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_in_ready",  64'(in_ready),   64'd0);
    check_val("rst_res_valid", 64'(res_valid),  64'd0);
    check_val("rst_res_data",  64'(res_data),   64'd0);
    check_val("rst_dsp_a",     64'(dsp_a),      64'd0);
    check_val("rst_dsp_b",     64'(dsp_b),      64'd0);
    check_val("rst_opmode",    64'(dsp_opmode), 64'h00);
    check_val("rst_busy",      64'(busy),       64'd0);
    check_val("rst_ce",        64'(dsp_ce),     64'd1);
    check_val("rst_dsp_rst",   64'(dsp_rst),    64'd1);
    check_val("rst_carryin",   64'(dsp_carryin), 64'd0);
  endtask

  task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b, output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (in_ready) begin
        ok = 1;
        acc_cyc = ncyc;
      end
      step();
      if (ok) break;
    end
    in_valid = 1'b0;
    check_val("accept_seen", 64'(ok), 64'd1);
  endtask

  task automatic run_job(input int n, input int gap, output int acc_first, output int acc_second);
    logic [PW-1:0] acc;
    int c;
    acc = '0;
    for (int i = 0; i < n; i++) acc = acc + prod_ext(job_a[i], job_b[i]);
    sb.push_back(acc);
    acc_first = -1;
    acc_second = -1;
    start = 1'b1; len = LEN_W'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_pair(job_a[i], job_b[i], c);
      if (i == 0) acc_first = c;
      if (i == 1) acc_second = c;
      if (i == 0) repeat (gap) step();
    end
  endtask

  // Cycles from the cycle after the last acceptance (k=1) until res_valid is seen.
  task automatic wait_result(output int k);
    bit found;
    found = 0;
    k = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      k++;
      if (res_valid) begin
        found = 1;
        break;
      end
    end
    step();
    check_val("result_seen", 64'(found), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "time limit");
  end

  initial begin
    int k, c0, c1;
    RSTN = 1'b0; start = 1'b0; len = '0; in_a = '0; in_b = '0;
    in_valid = 1'b0; res_ready = 1'b1;
    step(); step();
    @(negedge CLK);
    check_reset_outputs();
    step();
    RSTN = 1'b1;
    step();
    @(negedge CLK);
    check_val("post_rst_dsp_rst", 64'(dsp_rst), 64'd0);
    check_val("idle_opmode", 64'(dsp_opmode), 64'h08);
    check_val("idle_busy", 64'(busy), 64'd0);
    step();

    // Back-to-back len=3 -> 68, latency 6, one-cycle res_valid
    job_a[0] = 2; job_b[0] = 3; job_a[1] = 4; job_b[1] = 5; job_a[2] = 6; job_b[2] = 7;
    run_job(3, 0, c0, c1);
    wait_result(k);
    check_val("latency_len3", 64'(k), 64'd6);
    @(negedge CLK);
    check_val("res_valid_one_cycle", 64'(res_valid), 64'd0);
    check_val("back_to_idle", 64'(busy), 64'd0);
    step();

    // Two bubble cycles between pairs 1 and 2
    run_job(3, 2, c0, c1);
    wait_result(k);
    check_val("gap_spacing", 64'(c1 - c0), 64'd3);
    check_val("opm_first", 64'(opm_hist[(c0 + OPM_DLY) % 4096]), 64'h01);
    check_val("opm_bubble1", 64'(opm_hist[(c0 + OPM_DLY + 1) % 4096]), 64'h08);
    check_val("opm_bubble2", 64'(opm_hist[(c0 + OPM_DLY + 2) % 4096]), 64'h08);
    check_val("opm_accum", 64'(opm_hist[(c1 + OPM_DLY) % 4096]), 64'h09);
    step();

    // len=1 with result back-pressure; stray in_valid must not be taken
    res_ready = 1'b0;
    job_a[0] = 100; job_b[0] = 200;
    run_job(1, 0, c0, c1);
    wait_result(k);
    in_a = 77; in_b = 77; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_val("stall_res_valid", 64'(res_valid), 64'd1);
      check_val("stall_res_data", 64'(res_data), 64'd20000);
      check_val("stall_busy", 64'(busy), 64'd1);
      check_val("stall_in_ready", 64'(in_ready), 64'd0);
      check_val("stall_dsp_a", 64'(dsp_a), 64'd100);
      step();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge CLK);
    step();
    @(negedge CLK);
    check_val("stall_release_valid", 64'(res_valid), 64'd0);
    check_val("stall_release_busy", 64'(busy), 64'd0);
    step();

    // Back-to-back jobs: no carry-over of the previous accumulation
    job_a[0] = 5; job_b[0] = 5;
    run_job(1, 0, c0, c1);
    wait_result(k);
    step();
    job_a[0] = 1; job_b[0] = 1; job_a[1] = 2; job_b[1] = 2;
    run_job(2, 0, c0, c1);
    wait_result(k);
    check_val("latency_len2", 64'(k), 64'd6);
    step();

    // len=0: immediate zero result, no operand consumed
    in_a = 9; in_b = 9; in_valid = 1'b1;
    run_job(0, 0, c0, c1);
    wait_result(k);
    check_val("len0_latency", 64'(k), 64'd1);
    check_val("len0_no_accept", 64'(dsp_a), 64'd2);
    in_valid = 1'b0;
    step();

    // Reset in the middle of a len=4 job
    start = 1'b1; len = 4;
    step();
    start = 1'b0;
    send_pair(18'd7, 18'd8, c0);
    send_pair(18'd9, 18'd10, c0);
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    @(negedge CLK);
    check_reset_outputs();
    step();
    @(negedge CLK);
    check_val("rst_pulse_end", 64'(dsp_rst), 64'd0);
    step();
    job_a[0] = 3; job_b[0] = 3;
    run_job(1, 0, c0, c1);
    wait_result(k);
    step();

    // Randomised signed jobs
    for (int j = 0; j < 4; j++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        job_a[i] = N'($urandom);
        job_b[i] = N'($urandom);
      end
      run_job(n, $urandom_range(0, 2), c0, c1);
      wait_result(k);
      check_val("latency_rand", 64'(k), 64'd6);
      step();
    end

    repeat (3) step();
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_dot_ctrl.md
Name: dsp_dot_ctrl

Overview:
- Sequencer that drives one DSP slice as a multiply-accumulate engine and computes dot products of length len.
- Accepts operand pairs on a valid/ready stream and issues them, with per-element opmodes, to the slice's A/B/OPMODE ports.
- Tracks the slice's fixed pipeline latency, captures the accumulated PCOUT when the last product lands, and returns it on a valid/ready result port.
- Sits between the datapath front end and the DSP slice, which runs with all pipeline registers enabled (A0/A1/B0/B1/M/P/OPMODE/CARRYIN = 1, BINPUT direct, preadder bypassed).

Parameters:
- N, 18, operand width.
- PW, 48, accumulator/result width.
- LEN_W, 8, width of len.
- OPM_DLY, 3, cycles from operand acceptance to the matching opmode on dsp_opmode.
- P_DLY, 5, cycles from operand acceptance until its accumulated P is visible on dsp_p.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RSTN  in  1  synchronous active-low reset.
- start  in  1  begin a dot product; sampled only in IDLE.
- len  in  LEN_W  number of pairs; sampled with start.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid & in_ready.
- res_data  out  PW  dot-product result.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when res_valid & res_ready.
- busy  out  1  high in every state except IDLE.
- dsp_a  out  N  to slice A.
- dsp_b  out  N  to slice B.
- dsp_opmode  out  8  to slice opmode.
- dsp_carryin  out  1  to slice CARRYIN; constant 0.
- dsp_ce  out  1  drives all slice CE pins.
- dsp_rst  out  1  drives all slice RST pins; active high.
- dsp_p  in  PW  from slice PCOUT.

Behaviour:
- Reset (RSTN=0 at a clock edge): state=IDLE; in_ready=0, res_valid=0, res_data=0, dsp_a=0, dsp_b=0, dsp_opmode=8'h00, busy=0, dsp_ce=1, dsp_rst=1. The tag pipeline and counters are cleared.
- dsp_rst is a register: it is 1 during the first cycle after reset and 0 thereafter.
- States:
  - IDLE: start=1 and len!=0 → RUN; latch remaining=len, first=1. start=1 and len=0 → DONE with res_data=0. start is ignored in all other states.
  - RUN: in_ready=1. Each accepted pair registers dsp_a<=in_a, dsp_b<=in_b (visible the next cycle), decrements remaining, and pushes a valid tag {first,last}. When the last pair is accepted → DRAIN.
  - DRAIN: in_ready=0. Wait until the last tag reaches stage P_DLY.
  - DONE: res_valid=1 and res_data stable until res_ready. On handshake → IDLE, with res_valid=0 in the next cycle.
- Tag pipeline: a P_DLY-deep shift register of {valid,first,last}, advancing every cycle.
  - A cycle in RUN with no acceptance pushes valid=0 (a bubble). dsp_a/dsp_b then hold their previous values.
- dsp_opmode is registered from the tag at stage OPM_DLY-1, so it is visible OPM_DLY cycles after acceptance:
  - valid&first → 8'h01 (X=M, Z=0: restart the accumulator).
  - valid&!first → 8'h09 (X=M, Z=P: accumulate).
  - bubble → 8'h08 (X=0, Z=P: hold).
  - Bits 7:4 are always 0 (add, no preadder, carry 0).
  - Outside RUN/DRAIN the opmode is 8'h08.
- Capture: when the stage-P_DLY tag is valid&last, res_data<=dsp_p and the state moves DRAIN→DONE. res_valid is therefore first high P_DLY+1 cycles after the last acceptance.
- dsp_ce is held at 1 always; stalls are handled with bubbles, never by gating CE.
- Back-pressure: an in_valid presented outside RUN is never accepted. res_ready low holds DONE indefinitely; the slice P register holds because the opmode is 8'h08.
- Back-to-back jobs: a new start is possible only after the DONE handshake. The next job's first opmode 8'h01 discards the old P.
- Reset mid-operation: immediate return to IDLE. The partial result is lost and dsp_rst clears the slice.
- Arithmetic: width-transparent. Sign and overflow behaviour are those of the slice; the accumulator wraps modulo 2^PW.

Test Plan:
- len=3, pairs (2,3),(4,5),(6,7) back-to-back, res_ready=1 → res_data=68; res_valid rises exactly 6 cycles after the third acceptance, for one cycle.
- len=3 with in_valid low for 2 cycles between pairs 1 and 2, same data → res_data=68; dsp_opmode=8'h08 during the bubble slots.
- len=1 pair (100,200), res_ready held 0 for 10 cycles → res_valid stays 1, res_data=20000 stable, busy=1, in_ready=0; handshake → IDLE.
- Job (5,5) followed by job (1,1)+(2,2) → results 25 then 5 (no carry-over of the first result).
- start with len=0 → res_valid next cycle with res_data=0, no operands accepted.
- RSTN low for one cycle mid-RUN of a len=4 job → all outputs return to reset values, dsp_rst=1 for one cycle; a fresh job (3,3) afterwards returns 9.
